// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : Bridges a 32-bit MEM-stage load/store port to a 16-bit
//               external SRAM using two half-word phases (LOW, then HIGH).
//               Optional macro SRAM_RANGE_CHECK_EN rejects requests that are
//               out of range or unaligned without touching the SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N
);

    localparam logic [31:0] c_BASE = 32'd1024;
    localparam logic [3:0]  c_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state_q, w_state_d;
    logic [3:0]  r_cnt_q, w_cnt_d;
    logic        r_write_q, w_write_d;
    logic [16:0] r_word_q, w_word_d;
    logic [31:0] r_wdata_q, w_wdata_d;
    logic [31:0] r_rdata_q, w_rdata_d;
    logic [17:0] r_sram_addr_q, w_sram_addr_d;

    logic [31:0] w_offset;
    logic [16:0] w_word_index;
    logic        w_req;
    logic        w_last;
    logic        w_drive;
    logic        w_unused_bits;

    assign w_offset      = address - c_BASE;
    assign w_word_index  = w_offset[18:2];
    assign w_unused_bits = ^{w_offset[31:19], w_offset[1:0]};
    assign w_req         = wr_en | rd_en;
    assign w_last        = (r_cnt_q == c_LAST);

`ifdef SRAM_RANGE_CHECK_EN
    logic w_out_of_range;
    assign w_out_of_range = (address < c_BASE)
                         || (address >= (c_BASE + 32'h0008_0000))
                         || (address[1:0] != 2'b00);
`endif

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q + 4'd1;
        w_write_d     = r_write_q;
        w_word_d      = r_word_q;
        w_wdata_d     = r_wdata_q;
        w_rdata_d     = r_rdata_q;
        w_sram_addr_d = r_sram_addr_q;
        ready         = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                w_cnt_d = 4'd0;
                ready   = ~w_req;
                if (w_req) begin
                    // A simultaneous load and store is treated as a store.
                    w_write_d     = wr_en;
                    w_word_d      = w_word_index;
                    w_wdata_d     = write_data;
                    w_state_d     = S_LOW;
                    w_sram_addr_d = {w_word_index, 1'b0};
`ifdef SRAM_RANGE_CHECK_EN
                    if (w_out_of_range) begin
                        w_state_d     = S_DONE;
                        w_sram_addr_d = r_sram_addr_q;
                        if (!wr_en) begin
                            w_rdata_d = 32'd0;
                        end
                    end
`endif
                end
            end
            S_LOW: begin
                if (w_last) begin
                    w_state_d     = S_HIGH;
                    w_cnt_d       = 4'd0;
                    w_sram_addr_d = {r_word_q, 1'b1};
                    if (!r_write_q) begin
                        w_rdata_d[15:0] = SRAM_DQ;
                    end
                end
            end
            S_HIGH: begin
                if (w_last) begin
                    w_state_d = S_DONE;
                    w_cnt_d   = 4'd0;
                    if (!r_write_q) begin
                        w_rdata_d[31:16] = SRAM_DQ;
                    end
                end
            end
            S_DONE: begin
                ready     = 1'b1;
                w_cnt_d   = 4'd0;
                w_state_d = S_IDLE;
            end
            default: begin
                w_cnt_d   = 4'd0;
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_cnt_q       <= 4'd0;
            r_write_q     <= 1'b0;
            r_word_q      <= 17'd0;
            r_wdata_q     <= 32'd0;
            r_rdata_q     <= 32'd0;
            r_sram_addr_q <= 18'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_write_q     <= w_write_d;
            r_word_q      <= w_word_d;
            r_wdata_q     <= w_wdata_d;
            r_rdata_q     <= w_rdata_d;
            r_sram_addr_q <= w_sram_addr_d;
        end
    end

    // Bus is only ever driven during the two phases of a store.
    assign w_drive   = r_write_q && ((r_state_q == S_LOW) || (r_state_q == S_HIGH));
    assign SRAM_WE_N = ~w_drive;
    assign SRAM_DQ   = w_drive ? ((r_state_q == S_HIGH) ? r_wdata_q[31:16] : r_wdata_q[15:0])
                               : 16'hzzzz;
    assign SRAM_ADDR = r_sram_addr_q;
    assign read_data = r_rdata_q;

endmodule
`default_nettype wire
